sfu_bank_pipe: RTL and testbench

SFU_BANK_PIPE -- requirements
Module: sfu_bank_pipe

---
 rtl/sfu_bank_pipe.sv | 125 ++++++++++++
 tb/tb_sfu_bank_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_bank_pipe.sv
// Two-stage SFU lane bank: stage 1 accumulates, stage 2 applies relu/shift/narrow/mask.
// Define SFU_BANK_PIPE_SAT_EN to saturate rather than wrap when narrowing to out_bw.
module sfu_bank_pipe #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 32,
  parameter int unsigned out_bw  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic [col*psum_bw-1:0] psum_mem,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   acc,
  input  logic                   relu,
  input  logic [4:0]             shift,
  input  logic [col-1:0]         lane_en,
  output logic [col*out_bw-1:0]  psum_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            beat_cnt
);

  localparam int unsigned SumBw = psum_bw + 1;

  logic                        rdy_q;
  logic                        s1_valid_q;
  logic [col-1:0][SumBw-1:0]   s1_sum_q, s1_sum_d;
  logic                        s1_relu_q;
  logic [4:0]                  s1_shift_q;
  logic [col-1:0]              s1_lane_en_q;
  logic                        out_valid_q;
  logic [col*out_bw-1:0]       psum_out_q, psum_out_d;
  logic [15:0]                 beat_cnt_q;
  logic [col-1:0][SumBw-1:0]   relu_v;
  logic [col-1:0][out_bw-1:0]  nar_v;

  logic s2_adv, accept, s2_load;

  assign s2_adv   = !out_valid_q | out_ready;
  // rdy_q keeps in_ready low through reset and until the first edge after release.
  assign in_ready = rdy_q & (!s1_valid_q | s2_adv);
  assign accept   = in_valid & in_ready;
  assign s2_load  = s2_adv & s1_valid_q;

  assign psum_out  = psum_out_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;

  always_comb begin
    s1_sum_d = '0;
    for (int i = 0; i < col; i++) begin
      s1_sum_d[i] = {psum_in[(i+1)*psum_bw-1], psum_in[i*psum_bw +: psum_bw]}
                  + (acc ? {psum_mem[(i+1)*psum_bw-1], psum_mem[i*psum_bw +: psum_bw]}
                         : {SumBw{1'b0}});
    end
  end

`ifdef SFU_BANK_PIPE_SAT_EN
  localparam logic signed [SumBw-1:0] SatMax = {{(SumBw-out_bw+1){1'b0}}, {(out_bw-1){1'b1}}};
  localparam logic signed [SumBw-1:0] SatMin = {{(SumBw-out_bw+1){1'b1}}, {(out_bw-1){1'b0}}};
  logic [col-1:0][SumBw-1:0] shf_v;
`endif

  always_comb begin
    relu_v     = '0;
    nar_v      = '0;
    psum_out_d = '0;
`ifdef SFU_BANK_PIPE_SAT_EN
    shf_v      = '0;
`endif
    for (int i = 0; i < col; i++) begin
      relu_v[i] = (s1_relu_q && s1_sum_q[i][SumBw-1]) ? '0 : s1_sum_q[i];
`ifdef SFU_BANK_PIPE_SAT_EN
      shf_v[i] = SumBw'($signed(relu_v[i]) >>> s1_shift_q);
      if ($signed(shf_v[i]) > SatMax) begin
        nar_v[i] = SatMax[out_bw-1:0];
      end else if ($signed(shf_v[i]) < SatMin) begin
        nar_v[i] = SatMin[out_bw-1:0];
      end else begin
        nar_v[i] = shf_v[i][out_bw-1:0];
      end
`else
      // Shift at full sum width, then keep the low out_bw bits.
      nar_v[i] = out_bw'($signed(relu_v[i]) >>> s1_shift_q);
`endif
      psum_out_d[i*out_bw +: out_bw] = s1_lane_en_q[i] ? nar_v[i] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sum_q     <= '0;
      s1_relu_q    <= 1'b0;
      s1_shift_q   <= '0;
      s1_lane_en_q <= '0;
      out_valid_q  <= 1'b0;
      psum_out_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (accept) begin
        s1_sum_q     <= s1_sum_d;
        s1_relu_q    <= relu;
        s1_shift_q   <= shift;
        s1_lane_en_q <= lane_en;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
      end
      if (s2_load) begin
        psum_out_q <= psum_out_d;
      end
      if (out_valid_q && out_ready) begin
        beat_cnt_q <= beat_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sfu_bank_pipe.sv
// Scoreboard bench for sfu_bank_pipe: accepted beats are modelled with plain integer
// arithmetic and queued; a negedge monitor pops and compares each output transfer.
module tb_sfu_bank_pipe;

  localparam int Col    = 8;
  localparam int PsumBw = 32;
  localparam int OutBw  = 16;
  localparam int W      = Col * OutBw;
`ifdef SFU_BANK_PIPE_SAT_EN
  localparam int OvfWant = 32767;
`else
  localparam int OvfWant = -32768;
`endif

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b1;
  logic [Col*PsumBw-1:0] psum_in = '0;
  logic [Col*PsumBw-1:0] psum_mem = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic                  acc = 1'b0;
  logic                  relu = 1'b0;
  logic [4:0]            shift = '0;
  logic [Col-1:0]        lane_en = '1;
  logic [W-1:0]          psum_out;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [15:0]           beat_cnt;

  always #5 clk = ~clk;

  sfu_bank_pipe #(.col(Col), .psum_bw(PsumBw), .out_bw(OutBw)) dut (
    .clk(clk), .reset_n(reset_n), .psum_in(psum_in), .psum_mem(psum_mem),
    .in_valid(in_valid), .in_ready(in_ready), .acc(acc), .relu(relu), .shift(shift),
    .lane_en(lane_en), .psum_out(psum_out), .out_valid(out_valid), .out_ready(out_ready),
    .beat_cnt(beat_cnt)
  );

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: integer sum, clamp, floor-divide by 2^shift, narrow, mask.
  function automatic logic [W-1:0] model(input logic [Col*PsumBw-1:0] pin,
                                         input logic [Col*PsumBw-1:0] pmem,
                                         input logic a, input logic r,
                                         input logic [4:0] sh, input logic [Col-1:0] en);
    logic [W-1:0] res = '0;
    for (int i = 0; i < Col; i++) begin
      longint s, hi, lo;
      s = longint'($signed(pin[i*PsumBw +: PsumBw]));
      if (a) s += longint'($signed(pmem[i*PsumBw +: PsumBw]));
      if (r && s < 0) s = 0;
      s = s >>> sh;
      hi = (longint'(1) <<< (OutBw - 1)) - 1;
      lo = -hi - 1;
`ifdef SFU_BANK_PIPE_SAT_EN
      if (s > hi) s = hi;
      else if (s < lo) s = lo;
`endif
      if (en[i]) res[i*OutBw +: OutBw] = s[OutBw-1:0];
    end
    return res;
  endfunction

  logic         stalled = 1'b0;
  logic [W-1:0] last_out = '0;
  logic [W-1:0] want;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      model_cnt = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_vec("stall_hold_data", psum_out, last_out);
        check_bit("stall_hold_valid", out_valid, 1'b1);
      end
      stalled  = out_valid && !out_ready;
      last_out = psum_out;
      if (in_valid && in_ready) exp_q.push_back(model(psum_in, psum_mem, acc, relu, shift,
                                                      lane_en));
      if (out_valid && out_ready) begin
        check_bit("output_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check_vec("result", psum_out, want);
        end
        check16("beat_cnt", beat_cnt, 16'(model_cnt % 65536));
        model_cnt++;
      end
    end
  end

  function automatic logic [PsumBw-1:0] pick();
    int v;
    if ($urandom_range(0, 1) == 0) return $urandom;
    v = int'($urandom_range(0, 2000)) - 1000;
    return v;
  endfunction

  task automatic rand_beat();
    for (int i = 0; i < Col; i++) begin
      psum_in[i*PsumBw +: PsumBw]  = pick();
      psum_mem[i*PsumBw +: PsumBw] = pick();
    end
    acc     = 1'($urandom_range(0, 1));
    relu    = 1'($urandom_range(0, 1));
    shift   = 5'($urandom_range(0, 31));
    lane_en = 8'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b0);
    check_vec("rst_psum_out", psum_out, '0);
    check16("rst_beat_cnt", beat_cnt, 16'h0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    check_bit("in_ready_low_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1 check_bit("in_ready_after_reset", in_ready, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    check_bit("drain_in_time", n < 50, 1'b1);
  endtask

  // One beat into an empty pipe, checking two-edge latency and one lane's value.
  task automatic one_beat(input int lane, input logic [PsumBw-1:0] pin,
                          input logic [PsumBw-1:0] pmem, input logic a, input logic r,
                          input logic [4:0] sh, input logic [Col-1:0] en,
                          input int want_lane, input string name);
    psum_in  = '0;
    psum_mem = '0;
    psum_in[lane*PsumBw +: PsumBw]  = pin;
    psum_mem[lane*PsumBw +: PsumBw] = pmem;
    acc = a; relu = r; shift = sh; lane_en = en;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    check_bit({name, "_accept"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check_bit({name, "_lat1"}, out_valid, 1'b0);
    @(posedge clk);
    #1 check_bit({name, "_lat2"}, out_valid, 1'b1);
    check16(name, psum_out[lane*OutBw +: OutBw], 16'(want_lane));
  endtask

  int  sent;
  int  base;
  int  guard;
  logic saw_block;
  logic hold;
  logic need_new;

  initial begin
    do_reset();

    one_beat(0, 32'd100, -32'sd30, 1'b1, 1'b0, 5'd0, 8'hFF, 70, "basic_acc");
    @(posedge clk);
    #1 check16("basic_beat_cnt", beat_cnt, 16'd1);
    one_beat(1, -32'sd50, 32'd10, 1'b1, 1'b1, 5'd0, 8'hFF, 0, "relu_neg");
    one_beat(2, 32'd64, 32'd999, 1'b0, 1'b0, 5'd3, 8'hFF, 8, "shift_pos");
    one_beat(3, -32'sd9, 32'd5, 1'b0, 1'b0, 5'd1, 8'hFF, -5, "shift_neg");
    one_beat(0, 32'h7FFF, 32'h1, 1'b1, 1'b0, 5'd0, 8'hFF, OvfWant, "overflow");
    one_beat(5, 32'd1234, 32'd0, 1'b0, 1'b0, 5'd0, 8'hDF, 0, "lane_masked");
    one_beat(6, -32'sd1000, 32'd0, 1'b0, 1'b0, 5'd31, 8'hFF, -1, "big_shift_neg");
    drain();

    // Six beats back to back with a five-cycle downstream stall.
    base = model_cnt; sent = 0; saw_block = 1'b0; hold = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (!hold) rand_beat();
      in_valid  = (sent < 6);
      out_ready = !(c >= 3 && c <= 7);
      @(negedge clk);
      if (in_valid && !in_ready) saw_block = 1'b1;
      hold = in_valid && !in_ready;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
    end
    drain();
    check_bit("bp_in_ready_dropped", saw_block, 1'b1);
    check16("bp_beat_cnt", beat_cnt, 16'(base + 6));

    // Random valid/ready traffic; data held until accepted.
    need_new = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (need_new) begin
        rand_beat();
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      need_new = !in_valid || in_ready;
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with two beats held in the pipe.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_beat();
    @(posedge clk);
    #1 rand_beat();
    @(posedge clk);
    #1 check_bit("two_held_blocks_input", in_ready, 1'b0);
    do_reset();
    one_beat(4, 32'd7, 32'd8, 1'b1, 1'b0, 5'd0, 8'hFF, 15, "post_reset");
    drain();
    check16("post_reset_cnt", beat_cnt, 16'd1);

    // Counter wrap: 65536 transfers from reset bring beat_cnt back to zero.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sent = 0; guard = 0;
    while (sent < 65536 && guard < 70000) begin
      rand_beat();
      @(negedge clk);
      if (in_ready) sent++;
      @(posedge clk);
      #1 guard++;
    end
    check_bit("wrap_stream_in_time", guard < 70000, 1'b1);
    drain();
    check16("wrap_beat_cnt", beat_cnt, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
